// File: rtl/as_gpio_ctrl.sv
// as_gpio_ctrl: memory-mapped GPIO block with OUT/DIR/IN registers, cs_o strobe and pad synchronisers.
// Define AS_GPIO_IRQ_EN to compile in the IRQ_EN/STAT registers and the edge-interrupt logic.
module as_gpio_ctrl #(
    parameter int NR_GPIOS = 8,
    parameter int DATA_W   = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [5:0]          addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                ack_o,
    inout  wire  [NR_GPIOS-1:0] gpio_io,
    output logic                cs_o,
    output logic                irq_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    localparam logic [2:0] REG_OUT = 3'd0;
    localparam logic [2:0] REG_DIR = 3'd1;
    localparam logic [2:0] REG_IN  = 3'd2;

    logic [0:0]          r_state;
    logic [NR_GPIOS-1:0] r_out;
    logic [NR_GPIOS-1:0] r_dir;
    logic [NR_GPIOS-1:0] r_sync1;
    logic [NR_GPIOS-1:0] r_sync2;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_cs;

    logic                w_accept;
    logic                w_wr;
    logic [2:0]          w_sel;
    logic [NR_GPIOS-1:0] w_wdata;
    logic [NR_GPIOS-1:0] w_rd_gpio;
    logic [DATA_W-1:0]   w_rdata;

    assign w_sel    = addr_i[5:3];
    assign w_accept = (r_state == ST_IDLE) && req_i;
    assign w_wr     = w_accept && we_i;
    assign w_wdata  = wdata_i[NR_GPIOS-1:0];

    for (genvar g = 0; g < NR_GPIOS; g++) begin : g_pad
        assign gpio_io[g] = r_dir[g] ? r_out[g] : 1'bz;
    end

    logic w_unused_lo;
    assign w_unused_lo = ^addr_i[2:0];
    if (DATA_W > NR_GPIOS) begin : g_unused_hi
        logic w_unused_hi;
        assign w_unused_hi = ^wdata_i[DATA_W-1:NR_GPIOS];
    end

`ifdef AS_GPIO_IRQ_EN
    localparam logic [2:0] REG_IRQ_EN = 3'd3;
    localparam logic [2:0] REG_STAT   = 3'd4;

    logic [NR_GPIOS-1:0] r_irq_en;
    logic [NR_GPIOS-1:0] r_stat;
    logic [NR_GPIOS-1:0] r_prev;
    logic                r_irq;
    logic [NR_GPIOS-1:0] w_rise;
    logic [NR_GPIOS-1:0] w_clr;

    assign w_rise = r_sync2 & ~r_prev & ~r_dir;
    assign w_clr  = (w_wr && (w_sel == REG_STAT)) ? w_wdata : '0;

    // A new edge wins over a simultaneous write-1-to-clear of the same bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq_en <= '0;
            r_stat   <= '0;
            r_prev   <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_prev <= r_sync2;
            if (w_wr && (w_sel == REG_IRQ_EN))
                r_irq_en <= w_wdata;
            r_stat <= (r_stat & ~w_clr) | w_rise;
            r_irq  <= |(r_stat & r_irq_en);
        end
    end

    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        w_rd_gpio = '0;
        case (w_sel)
            REG_OUT:    w_rd_gpio = r_out;
            REG_DIR:    w_rd_gpio = r_dir;
            REG_IN:     w_rd_gpio = r_sync2;
`ifdef AS_GPIO_IRQ_EN
            REG_IRQ_EN: w_rd_gpio = r_irq_en;
            REG_STAT:   w_rd_gpio = r_stat;
`endif
            default:    w_rd_gpio = '0;
        endcase
        w_rdata = '0;
        w_rdata[NR_GPIOS-1:0] = w_rd_gpio;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_dir   <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_rdata <= '0;
            r_cs    <= 1'b0;
        end else begin
            r_sync1 <= gpio_io;
            r_sync2 <= r_sync1;
            r_cs    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_ACK;
                        r_rdata <= w_rdata;
                        if (w_wr && (w_sel == REG_OUT)) begin
                            r_out <= w_wdata;
                            r_cs  <= 1'b1;
                        end
                        if (w_wr && (w_sel == REG_DIR))
                            r_dir <= w_wdata;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rdata <= '0;
                end
            endcase
        end
    end

    // Reset landing during ACK suppresses the acknowledge in that same cycle.
    assign ack_o   = (r_state == ST_ACK) && !rst_i;
    assign cs_o    = r_cs && !rst_i;
    assign rdata_o = r_rdata;

endmodule

// File: tb/tb_as_gpio_ctrl.sv
// Self-checking bench for as_gpio_ctrl: vector table plus directed sequences for pads, IRQ and reset abort.
module tb_as_gpio_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [5:0]  addr_i;
    logic [63:0] wdata_i;
    logic [63:0] rdata_o;
    logic        ack_o;
    wire  [7:0]  gpio_io;
    logic        cs_o;
    logic        irq_o;

    logic [7:0]  tb_oe;
    logic [7:0]  tb_drv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < 8; g++) begin : g_tbpad
        assign gpio_io[g] = tb_oe[g] ? tb_drv[g] : 1'bz;
    end

    as_gpio_ctrl #(.NR_GPIOS(8), .DATA_W(64)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .ack_o   (ack_o),
        .gpio_io (gpio_io),
        .cs_o    (cs_o),
        .irq_o   (irq_o)
    );

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [63:0] wd;
        logic [63:0] exp_rd;
        logic        exp_cs;
        logic        chk_gp;
        logic [7:0]  exp_gp;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Caller is at posedge+1; returns at posedge+1 after the ACK cycle.
    task automatic txn(input logic we, input logic [5:0] addr, input logic [63:0] wd,
                       output logic [63:0] rd, output logic cs, output logic [7:0] gp,
                       output int lat, output logic ack_after, output logic cs_after);
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
        lat = 0;
        @(posedge clk_i); #1;
        while (!ack_o && lat < 8) begin
            @(posedge clk_i); #1;
            lat++;
        end
        rd = rdata_o; cs = cs_o; gp = gpio_io;
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        @(posedge clk_i); #1;
        ack_after = ack_o; cs_after = cs_o;
    endtask

    task automatic rd_chk(input string nm, input logic [5:0] addr, input logic [63:0] exp);
        logic [63:0] rd; logic cs, aa, ca; logic [7:0] gp; int lat;
        txn(1'b0, addr, 64'h0, rd, cs, gp, lat, aa, ca);
        chk({nm, "_lat"}, 64'(lat), 64'd0);
        chk(nm, rd, exp);
    endtask

    task automatic wr(input logic [5:0] addr, input logic [63:0] wd);
        logic [63:0] rd; logic cs, aa, ca; logic [7:0] gp; int lat;
        txn(1'b1, addr, wd, rd, cs, gp, lat, aa, ca);
        chk("wr_lat", 64'(lat), 64'd0);
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        logic [63:0] rd;
        logic        cs, aa, ca;
        logic [7:0]  gp;
        int          lat;

        tbl[0]  = '{1'b0, 6'h00, 64'h0,                  64'h0,  1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 6'h08, 64'h0,                  64'h0,  1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 6'h08, 64'hFF,                 64'h0,  1'b0, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 6'h00, 64'h89,                 64'h0,  1'b1, 1'b1, 8'h89};
        tbl[4]  = '{1'b1, 6'h00, 64'h77,                 64'h0,  1'b1, 1'b1, 8'h77};
        tbl[5]  = '{1'b1, 6'h00, 64'h01,                 64'h0,  1'b1, 1'b1, 8'h01};
        tbl[6]  = '{1'b1, 6'h00, 64'hFE,                 64'h0,  1'b1, 1'b1, 8'hFE};
        tbl[7]  = '{1'b1, 6'h00, 64'hFE,                 64'h0,  1'b1, 1'b1, 8'hFE};
        tbl[8]  = '{1'b0, 6'h00, 64'h0,                  64'hFE, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 6'h0F, 64'h0,                  64'hFF, 1'b0, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 6'h10, 64'h0,                  64'hFE, 1'b0, 1'b0, 8'h00};
        tbl[11] = '{1'b1, 6'h38, 64'hFF,                 64'h0,  1'b0, 1'b1, 8'hFE};
        tbl[12] = '{1'b0, 6'h38, 64'h0,                  64'h0,  1'b0, 1'b0, 8'h00};
        tbl[13] = '{1'b1, 6'h10, 64'h00,                 64'h0,  1'b0, 1'b1, 8'hFE};
        tbl[14] = '{1'b0, 6'h00, 64'h0,                  64'hFE, 1'b0, 1'b0, 8'h00};
        tbl[15] = '{1'b1, 6'h00, 64'hFFFF_FFFF_FFFF_FF89, 64'h0, 1'b1, 1'b1, 8'h89};
        tbl[16] = '{1'b0, 6'h00, 64'h0,                  64'h89, 1'b0, 1'b0, 8'h00};

        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        tb_oe = '0; tb_drv = '0;

        // Reset held 10 cycles.
        wait_cyc(10);
        chk("rst_ack", 64'(ack_o), 64'd0);
        chk("rst_cs", 64'(cs_o), 64'd0);
        chk("rst_rdata", rdata_o, 64'd0);
        chk("rst_irq", 64'(irq_o), 64'd0);
        rst_i = 1'b0;
        wait_cyc(1);
        chk("post_rst_ack", 64'(ack_o), 64'd0);

        // All pads inputs after reset: external pattern is visible on IN.
        tb_oe = 8'hFF; tb_drv = 8'h5A;
        wait_cyc(3);
        rd_chk("in_after_rst", 6'h10, 64'h5A);
        tb_oe = '0;
        wait_cyc(2);

        for (int i = 0; i < 17; i++) begin
            txn(tbl[i].we, tbl[i].addr, tbl[i].wd, rd, cs, gp, lat, aa, ca);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'd0);
            chk($sformatf("v%0d_cs", i), 64'(cs), 64'(tbl[i].exp_cs));
            chk($sformatf("v%0d_ack_1cyc", i), 64'(aa), 64'd0);
            chk($sformatf("v%0d_cs_1cyc", i), 64'(ca), 64'd0);
            if (!tbl[i].we)
                chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
            if (tbl[i].chk_gp)
                chk($sformatf("v%0d_gpio", i), 64'(gp), 64'(tbl[i].exp_gp));
        end

        // Mixed direction: low nibble driven from OUT=0x89, high nibble external 0xA.
        wr(6'h08, 64'h0F);
        tb_drv = 8'hA0; tb_oe = 8'hF0;
        wait_cyc(3);
        rd_chk("in_mixed", 6'h10, 64'hA9);
        chk("gpio_mixed", 64'(gpio_io), 64'hA9);

`ifdef AS_GPIO_IRQ_EN
        wr(6'h08, 64'h00);
        tb_drv = 8'h00; tb_oe = 8'hFF;
        wait_cyc(4);
        wr(6'h20, 64'hFF);
        rd_chk("stat_cleared", 6'h20, 64'h0);
        wr(6'h18, 64'h10);
        rd_chk("irq_en_rd", 6'h18, 64'h10);
        wait_cyc(2);
        tb_drv[4] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk_i); #1;
            chk($sformatf("irq_lat_c%0d", k), 64'(irq_o), (k == 4) ? 64'd1 : 64'd0);
        end
        rd_chk("stat_set", 6'h20, 64'h10);

        // Second rising edge on pad4 lands on the same edge as a W1C of bit 4.
        tb_drv[4] = 1'b0;
        wait_cyc(4);
        tb_drv[4] = 1'b1;
        wait_cyc(2);
        req_i = 1'b1; we_i = 1'b1; addr_i = 6'h20; wdata_i = 64'h10;
        @(posedge clk_i); #1;
        chk("w1c_coll_ack", 64'(ack_o), 64'd1);
        req_i = 1'b0; we_i = 1'b0;
        @(posedge clk_i); #1;
        rd_chk("stat_set_wins", 6'h20, 64'h10);
        chk("irq_still", 64'(irq_o), 64'd1);
        wr(6'h20, 64'h10);
        rd_chk("stat_w1c", 6'h20, 64'h0);
        chk("irq_cleared", 64'(irq_o), 64'd0);
`else
        wr(6'h18, 64'hFF);
        rd_chk("unmapped_r3", 6'h18, 64'h0);
        wr(6'h20, 64'hFF);
        rd_chk("unmapped_r4", 6'h20, 64'h0);
        chk("irq_tied", 64'(irq_o), 64'd0);
`endif

        // Reset one cycle after acceptance aborts the transaction.
        tb_oe = '0;
        wr(6'h08, 64'hFF);
        req_i = 1'b1; we_i = 1'b1; addr_i = 6'h00; wdata_i = 64'h33;
        @(posedge clk_i); #1;
        chk("abort_gpio_new", 64'(gpio_io), 64'h33);
        rst_i = 1'b1;
        #1;
        chk("abort_ack", 64'(ack_o), 64'd0);
        chk("abort_cs", 64'(cs_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0;
        chk("abort_ack_after", 64'(ack_o), 64'd0);
        chk("abort_rdata", rdata_o, 64'd0);
        @(posedge clk_i); #1;
        chk("abort_no_late_ack", 64'(ack_o), 64'd0);
        rd_chk("abort_out", 6'h00, 64'h0);
        rd_chk("abort_dir", 6'h08, 64'h0);
        chk("abort_irq", 64'(irq_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/as_gpio_ctrl.md
# as_gpio_ctrl

Memory-mapped GPIO controller between the RV64I core's data-memory bus and the `gpio_io` pads of `as_top_mem`. It owns the output/direction registers that drive `gpio_io`, and the `cs_o` strobe the integration benches sample to check results. It also synchronises pad inputs for read-back and optional edge interrupts.

## Interface
Parameters:
- `NR_GPIOS`, 8: number of GPIO pins (1..64).
- `DATA_W`, 64: bus data width.

Ports:
- `clk_i`  in  1  core clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  1  bus request; held until `ack_o`.
- `we_i`  in  1  1 = write, 0 = read; valid with `req_i`.
- `addr_i`  in  6  byte address; bits [5:3] select register, bits [2:0] ignored.
- `wdata_i`  in  DATA_W  write data; low NR_GPIOS bits used.
- `rdata_o`  out  DATA_W  read data; valid while `ack_o`=1, zero-extended.
- `ack_o`  out  1  one-cycle transaction acknowledge.
- `gpio_io`  inout  NR_GPIOS  pads; bit i driven with OUT[i] when DIR[i]=1, else 'z.
- `cs_o`  out  1  one-cycle strobe after an accepted OUT write.
- `irq_o`  out  1  level interrupt (see Configuration).

## Operation
Register map (index = addr_i[5:3]):
- 0 OUT: RW. 1 DIR: RW, 1 = output. 2 IN: RO, synchronised pad value. 3 IRQ_EN: RW. 4 IRQ_STAT: read, write-1-to-clear. 5..7: unmapped.

Unmapped or RO writes are ignored. Unmapped reads return 0. `ack_o` is still given.

FSM with two states, IDLE and ACK:
- IDLE and `req_i`=1: the write takes effect on this edge; read data is captured into `rdata_o`. Go to ACK.
- ACK: `ack_o`=1. Always return to IDLE. `req_i` is not sampled in ACK.
- The master must drop `req_i` in the cycle after it sees `ack_o`. A `req_i` still high in the next IDLE cycle starts a new transaction.
- Minimum transaction: 2 cycles; back-to-back throughput is 1 per 2 cycles.

Input path:
- Each pad passes through a 2-FF synchroniser. IN reads the second stage.
- For a pin configured as output, IN reads back the driven value.

Strobe:
- `cs_o`=1 for exactly one cycle, during ACK of an OUT write, including rewrites of the same value.
- `gpio_io` already shows the new value in that cycle.

Edge interrupt (macro enabled):
- STAT[i] is set when sync2[i] rises (previous 0, current 1) and DIR[i]=0.
- `irq_o` = |(STAT & IRQ_EN), registered.
- If a W1C and a new edge hit the same bit in the same cycle, set wins.

Reset: `rst_i` mid-transaction aborts it. The FSM goes to IDLE, no `ack_o` is issued, and the master must re-issue.

## Timing
- Reset values:
  - `ack_o`=0, `rdata_o`=0, `cs_o`=0, `irq_o`=0.
  - OUT=0, DIR=0 (all pads 'z), IRQ_EN=0, STAT=0.
  - Synchroniser flops = 0.
- Write: `req_i` seen at edge N. Register updates at N. `ack_o` and `cs_o` are high in cycle N..N+1.
- Read: `rdata_o` is valid with `ack_o`, one cycle after acceptance.
- Pad-to-IN latency: 2 cycles. Pad-to-`irq_o`: 4 cycles (2 sync, 1 edge/STAT, 1 irq register).
- `gpio_io` changes at the same edge OUT/DIR update, combinationally from those registers.

## Configuration
`AS_GPIO_IRQ_EN`:
- Defined: IRQ_EN/STAT registers, edge detection and `irq_o` logic are compiled in.
- Undefined: registers 3 and 4 behave as unmapped (read 0, writes ignored) and `irq_o` is tied 0. Edge-detect flops are not present.

## Test plan
- Reset: hold `rst_i` for 10 cycles -> all outputs 0, `gpio_io`='z, read of OUT and DIR returns 0.
- Write DIR=0xFF, then OUT=0x89 -> `gpio_io`=137 and `cs_o` high for one cycle aligned with `ack_o`. Then OUT=0x77, 0x01, 0xFE -> `cs_o` pulses with 119, 1, 254; no `cs_o` on the DIR write.
- DIR=0x0F, pads [7:4] driven externally to 0xA -> after 2 cycles a read of IN returns 0xA9 (low nibble from OUT=0x89); `gpio_io`[7:4] are not driven by the block.
- Write to address 0x38 and read it -> no state change, `rdata_o`=0, `ack_o` still given in 2 cycles.
- With `AS_GPIO_IRQ_EN`: IRQ_EN=0x10, DIR=0, pad4 0->1 -> `irq_o`=1 four cycles later. A W1C 0x10 in the same cycle as a second rising edge -> STAT[4] remains 1.
- Assert `rst_i` in the cycle after `req_i` is accepted -> no `ack_o`, all registers return to reset values.
